// File: rtl/hacd_comp_sched.sv
// Serialises page-compression jobs from NUM_REQ requesters onto one compressor:
// fetch -> compress -> release -> writeback -> respond. Optional stats: HACD_COMP_SCHED_STATS_EN.
module hacd_comp_sched #(
  parameter int NUM_REQ         = 2,
  parameter int PAGE_ADDR_WIDTH = 36,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*PAGE_ADDR_WIDTH-1:0] req_page_addr,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               fetch_req,
  output logic [PAGE_ADDR_WIDTH-1:0]         fetch_addr,
  input  logic                               fetch_done,
  input  logic                               fetch_err,
  output logic                               comp_start,
  input  logic                               comp_done,
  input  logic                               comp_incompressible,
  input  logic [13:0]                        comp_size,
  output logic                               wb_req,
  output logic [PAGE_ADDR_WIDTH-1:0]         wb_addr,
  output logic [13:0]                        wb_size,
  input  logic                               wb_done,
  output logic                               rsp_valid,
  output logic [NUM_REQ-1:0]                 rsp_grant,
  output logic [1:0]                         rsp_status,
  output logic [13:0]                        rsp_size,
  output logic                               busy,
  output logic [15:0]                        stat_comp_cnt,
  output logic [15:0]                        stat_incomp_cnt,
  output logic [15:0]                        stat_err_cnt
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_COMP    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_RESPOND = 3'd5;

  localparam logic [1:0] ST_COMP    = 2'd0;
  localparam logic [1:0] ST_INCOMP  = 2'd1;
  localparam logic [1:0] ST_FETCHER = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  logic [2:0]                 r_state;
  logic [GW-1:0]              r_rr;
  logic [GW-1:0]              r_grant;
  logic [NUM_REQ-1:0]         r_req_ready;
  logic [PAGE_ADDR_WIDTH-1:0] r_addr;
  logic [13:0]                r_size;
  logic [1:0]                 r_status;
  logic [CW-1:0]              r_cnt;
  logic [GW-1:0]              w_gidx;
  logic                       w_timeout;

  // First asserted request at or after the pointer, wrapping; lowest offset wins.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [GW-1:0] p);
    logic [GW-1:0] g;
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (v[(int'(p) + k) % NUM_REQ]) g = GW'((int'(p) + k) % NUM_REQ);
    end
    return g;
  endfunction

  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
    return GW'((int'(g) + 1) % NUM_REQ);
  endfunction

  assign w_gidx    = rr_pick(req_valid, r_rr);
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_req_ready <= '0;
    end else begin
      r_req_ready <= '0;
      case (r_state)
        S_IDLE: if (|req_valid) begin
          r_req_ready <= NUM_REQ'(1) << w_gidx;
          r_rr        <= rr_next(w_gidx);
          r_state     <= S_FETCH;
        end
        S_FETCH: begin
          if (fetch_err)       r_state <= S_RESPOND;
          else if (fetch_done) r_state <= S_COMP;
        end
        S_COMP: begin
          if (comp_done)                r_state <= S_RELEASE;
          else if (comp_incompressible) r_state <= S_RESPOND;
          else if (w_timeout)           r_state <= S_RELEASE;
        end
        // Hold off until the compressor drops done so the next job starts clean.
        S_RELEASE: if (!comp_done) r_state <= (r_status == ST_COMP) ? S_WB : S_RESPOND;
        S_WB:      if (wb_done) r_state <= S_RESPOND;
        S_RESPOND: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Job payload; only read while the owning state is active, so no reset.
  always_ff @(posedge clk_i) begin
    case (r_state)
      S_IDLE: if (|req_valid) begin
        r_grant <= w_gidx;
        r_addr  <= req_page_addr[int'(w_gidx)*PAGE_ADDR_WIDTH +: PAGE_ADDR_WIDTH];
      end
      S_FETCH: begin
        r_cnt <= '0;
        if (fetch_err) r_status <= ST_FETCHER;
      end
      S_COMP: begin
        r_cnt <= r_cnt + CW'(1);
        if (comp_done) begin
          r_size   <= comp_size;
          r_status <= ST_COMP;
        end else if (comp_incompressible) begin
          r_status <= ST_INCOMP;
        end else if (w_timeout) begin
          r_status <= ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = r_req_ready;
  assign fetch_req  = (r_state == S_FETCH);
  assign fetch_addr = fetch_req ? r_addr : '0;
  assign comp_start = (r_state == S_COMP);
  assign wb_req     = (r_state == S_WB);
  assign wb_addr    = wb_req ? r_addr : '0;
  assign wb_size    = wb_req ? r_size : '0;
  assign rsp_valid  = (r_state == S_RESPOND);
  assign rsp_grant  = rsp_valid ? (NUM_REQ'(1) << r_grant) : '0;
  assign rsp_status = rsp_valid ? r_status : '0;
  assign rsp_size   = (rsp_valid && (r_status == ST_COMP)) ? r_size : '0;
  assign busy       = (r_state != S_IDLE);

`ifdef HACD_COMP_SCHED_STATS_EN
  logic [15:0] r_stat_comp, r_stat_incomp, r_stat_err;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_comp   <= '0;
      r_stat_incomp <= '0;
      r_stat_err    <= '0;
    end else if (rsp_valid) begin
      case (r_status)
        ST_COMP:   r_stat_comp   <= sat_inc(r_stat_comp);
        ST_INCOMP: r_stat_incomp <= sat_inc(r_stat_incomp);
        default:   r_stat_err    <= sat_inc(r_stat_err);
      endcase
    end
  end

  assign stat_comp_cnt   = r_stat_comp;
  assign stat_incomp_cnt = r_stat_incomp;
  assign stat_err_cnt    = r_stat_err;
`else
  assign stat_comp_cnt   = '0;
  assign stat_incomp_cnt = '0;
  assign stat_err_cnt    = '0;
`endif

endmodule
